temp_meas_sched: RTL and testbench
==================================

Name: temp_meas_sched

Overview:
- Sequencer for the temperature-oscillator measurement path.
- Runs on the 32768 Hz lf_clk and owns the oscillator enable (ana_en).
- Consumes delta/delta_valid from temp_osc_measure and averages 2^AVG_LOG2 windows into one result.
- Applies high/low alarm thresholds; supports single-shot and periodic (continuous) modes with a timeout watchdog.

Parameters:
- DW, 8, width of delta, result and thresholds
- AVG_LOG2, 2, log2 of windows averaged per result (1..4)
- SETTLE_CYC, 4, lf_clk cycles ana_en is held high before windows are counted
- TIMEOUT_CYC, 64, max lf_clk cycles between accepted delta_valid pulses in MEAS

Ports:
- lf_clk  in  1  low-frequency clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a measurement; ignored while busy=1
- stop  in  1  abort; returns to IDLE next cycle, has priority over start
- continuous  in  1  periodic mode; sampled in DONE
- interval  in  8  lf_clk cycles spent in WAIT between results in continuous mode
- thr_hi  in  DW  high alarm threshold
- thr_lo  in  DW  low alarm threshold
- delta  in  DW  window count from temp_osc_measure
- delta_valid  in  1  one-cycle strobe, delta valid
- ana_en  out  1  oscillator enable (drives ui_in[0] path)
- busy  out  1  high in any state except IDLE
- result  out  DW  averaged count, held until next result
- result_valid  out  1  one-cycle strobe with each new result
- alarm_hi  out  1  result > thr_hi
- alarm_lo  out  1  result < thr_lo
- timeout_err  out  1  sticky; set on watchdog expiry, cleared by next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and accumulator 0.
- IDLE: ana_en=0. On start=1 and stop=0: clear timeout_err, go to SETTLE with settle counter 0.
- SETTLE: ana_en=1. After SETTLE_CYC cycles go to MEAS with acc=0, sample count=0, discard flag=1.
- MEAS: ana_en=1.
  - First delta_valid is discarded (partial window) and clears the discard flag.
  - Each later delta_valid adds delta into acc (DW+AVG_LOG2 bits, no overflow possible).
  - On the 2^AVG_LOG2-th accepted sample go to DONE.
  - Watchdog counts cycles since entering MEAS or since the last delta_valid; reset by any delta_valid.
  - Watchdog reaching TIMEOUT_CYC: set timeout_err, go to IDLE, leave result untouched, no result_valid.
- DONE (1 cycle):
  - result <= acc >> AVG_LOG2 (truncate); result_valid=1 this cycle.
  - alarm_hi/alarm_lo updated from the new result (strict compares).
  - continuous=1: go to WAIT. continuous=0: go to IDLE.
  - ana_en=0 from DONE onward.
- WAIT: ana_en=0. After interval cycles go to SETTLE. interval=0 means SETTLE directly the next cycle.
- stop=1 in any state: go to IDLE next cycle, ana_en=0, no result_valid, alarms and result held.
- start while busy: ignored.
- start and stop together: stop wins.
- delta_valid outside MEAS: ignored.
- thr_lo > thr_hi: both alarms may assert; no arbitration.
- Latency from start to result_valid: 1 + SETTLE_CYC + (1 + 2^AVG_LOG2) windows + 1 cycle.
- Asynchronous reset mid-operation: immediate return to reset values; ana_en drops without waiting for a clock.

Optional Feature:
- Macro: TEMP_SCHED_HYST_EN.
- Defined:
  - Parameter HYST (default 2) is added.
  - alarm_hi sets when result > thr_hi and clears only when result < thr_hi - HYST.
  - alarm_lo sets when result < thr_lo and clears only when result > thr_lo + HYST.
  - Subtractions saturate at 0 and additions at 2^DW-1.
  - Between the set and clear thresholds the alarm holds its value.
- Undefined: alarms are recomputed from each result with no memory. The HYST parameter does not exist.

Test Plan:
- Single shot, AVG_LOG2=2, delta stream 99(discard),100,102,104,106 -> one result_valid, result=103, busy low the cycle after DONE, ana_en high only during SETTLE/MEAS.
- thr_hi=100, thr_lo=50, result 103 then 40 -> alarm_hi=1/alarm_lo=0, then alarm_hi=0/alarm_lo=1. With TEMP_SCHED_HYST_EN, HYST=2, sequence 103,99 -> alarm_hi stays 1; then 97 -> alarm_hi clears.
- continuous=1, interval=10 -> result_valid pulses spaced by exactly 10 + SETTLE_CYC + 2 + window-alignment cycles. Drop continuous before a DONE -> IDLE after that result.
- No delta_valid after entering MEAS -> timeout_err=1 after TIMEOUT_CYC cycles, ana_en=0, result unchanged. Next start clears timeout_err.
- stop during MEAS after 2 samples, and start+stop in the same IDLE cycle -> IDLE, no result_valid, busy=0; start while busy has no effect on timing.
- rst_n low mid-MEAS -> ana_en, busy, result, alarms all 0 asynchronously; after release stays IDLE until start.

Source files
------------

// File: rtl/temp_meas_sched_if.sv
// Bundles the temperature-measurement scheduler's control, measurement and status signals.
// master drives requests and oscillator counts; slave is the scheduler itself.
interface temp_meas_sched_if #(
    parameter int DW = 8
);
    logic          start;
    logic          stop;
    logic          continuous;
    logic [7:0]    interval;
    logic [DW-1:0] thr_hi;
    logic [DW-1:0] thr_lo;
    logic [DW-1:0] delta;
    logic          delta_valid;
    logic          ana_en;
    logic          busy;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          alarm_hi;
    logic          alarm_lo;
    logic          timeout_err;

    modport master (
        output start, stop, continuous, interval, thr_hi, thr_lo, delta, delta_valid,
        input  ana_en, busy, result, result_valid, alarm_hi, alarm_lo, timeout_err
    );

    modport slave (
        input  start, stop, continuous, interval, thr_hi, thr_lo, delta, delta_valid,
        output ana_en, busy, result, result_valid, alarm_hi, alarm_lo, timeout_err
    );
endinterface

// File: rtl/temp_meas_sched.sv
// Settle / measure / average sequencer for the temperature oscillator on lf_clk.
// Define TEMP_SCHED_HYST_EN to give the alarms hysteresis of HYST counts.
module temp_meas_sched #(
    parameter int DW          = 8,
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 64
`ifdef TEMP_SCHED_HYST_EN
    ,
    parameter int HYST        = 2
`endif
) (
    input logic              lf_clk,
    input logic              rst_n,
    temp_meas_sched_if.slave bus
);
    // state  | meaning
    // IDLE   | oscillator off, waiting for start
    // SETTLE | oscillator on, letting it stabilise for SETTLE_CYC cycles
    // MEAS   | drop first (partial) window, accumulate 2^AVG_LOG2 windows
    // DONE   | one cycle: new result and alarms visible, result_valid high
    // WAIT   | continuous-mode gap of interval cycles before the next settle
    localparam int AW  = DW + AVG_LOG2;
    localparam int SW  = $clog2(SETTLE_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT_CYC + 1);
    localparam int DW1 = DW + 1;

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_MEAS, S_DONE, S_WAIT} state_t;

    state_t              state, state_nx;
    logic [SW-1:0]       settle_cnt;
    logic [TW-1:0]       wd_cnt;
    logic [7:0]          wait_cnt;
    logic [AVG_LOG2-1:0] samp_cnt;
    logic                discard;
    logic [AW-1:0]       acc;
    logic [AW-1:0]       acc_sum;
    logic [DW-1:0]       new_res;
    logic                new_hi, new_lo;
    logic                start_ok, take, publish, wd_exp;
    logic                ana_en_c, busy_c, rv_c;
    logic [DW-1:0]       result_q;
    logic                alarm_hi_q, alarm_lo_q, timeout_err_q;

    assign acc_sum = acc + AW'(bus.delta);
    assign new_res = acc_sum[AW-1:AVG_LOG2];

`ifdef TEMP_SCHED_HYST_EN
    logic [DW:0]   hi_clr_w, lo_clr_w;
    logic [DW-1:0] hi_clr, lo_clr;

    always_comb begin
        hi_clr_w = {1'b0, bus.thr_hi} - DW1'(HYST);
        lo_clr_w = {1'b0, bus.thr_lo} + DW1'(HYST);
        hi_clr   = hi_clr_w[DW] ? '0 : hi_clr_w[DW-1:0];
        lo_clr   = lo_clr_w[DW] ? '1 : lo_clr_w[DW-1:0];
        new_hi   = alarm_hi_q;
        new_lo   = alarm_lo_q;
        if (new_res > bus.thr_hi)
            new_hi = 1'b1;
        else if (new_res < hi_clr)
            new_hi = 1'b0;
        if (new_res < bus.thr_lo)
            new_lo = 1'b1;
        else if (new_res > lo_clr)
            new_lo = 1'b0;
    end
`else
    assign new_hi = new_res > bus.thr_hi;
    assign new_lo = new_res < bus.thr_lo;
`endif

    always_ff @(posedge lf_clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        take     = 1'b0;
        publish  = 1'b0;
        wd_exp   = 1'b0;
        ana_en_c = 1'b0;
        busy_c   = 1'b1;
        rv_c     = 1'b0;
        case (state)
            S_IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    start_ok = 1'b1;
                    state_nx = S_SETTLE;
                end
            end
            S_SETTLE: begin
                ana_en_c = 1'b1;
                if (settle_cnt == '0)
                    state_nx = S_MEAS;
            end
            S_MEAS: begin
                ana_en_c = 1'b1;
                if (bus.delta_valid) begin
                    take = !discard;
                    if (!discard && samp_cnt == '0) begin
                        publish  = 1'b1;
                        state_nx = S_DONE;
                    end
                end else if (wd_cnt == '0) begin
                    wd_exp   = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_DONE: begin
                rv_c = 1'b1;
                if (!bus.continuous)
                    state_nx = S_IDLE;
                else if (bus.interval == 8'd0)
                    state_nx = S_SETTLE;
                else
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt == 8'd0)
                    state_nx = S_SETTLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides everything, including a result that would land this cycle.
        if (bus.stop) begin
            state_nx = S_IDLE;
            start_ok = 1'b0;
            take     = 1'b0;
            publish  = 1'b0;
            wd_exp   = 1'b0;
        end
    end

    always_ff @(posedge lf_clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt    <= '0;
            wd_cnt        <= '0;
            wait_cnt      <= '0;
            samp_cnt      <= '0;
            discard       <= 1'b0;
            acc           <= '0;
            result_q      <= '0;
            alarm_hi_q    <= 1'b0;
            alarm_lo_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_nx == S_SETTLE && state != S_SETTLE)
                settle_cnt <= SW'(SETTLE_CYC - 1);
            else if (state == S_SETTLE)
                settle_cnt <= settle_cnt - SW'(1);

            if (state == S_DONE && state_nx == S_WAIT)
                wait_cnt <= bus.interval - 8'd1;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt - 8'd1;

            if (state == S_SETTLE && state_nx == S_MEAS) begin
                acc      <= '0;
                samp_cnt <= '1;
                discard  <= 1'b1;
                wd_cnt   <= TW'(TIMEOUT_CYC - 1);
            end else if (state == S_MEAS) begin
                if (bus.delta_valid) begin
                    wd_cnt  <= TW'(TIMEOUT_CYC - 1);
                    discard <= 1'b0;
                end else begin
                    wd_cnt <= wd_cnt - TW'(1);
                end
                if (take) begin
                    acc      <= acc_sum;
                    samp_cnt <= samp_cnt - AVG_LOG2'(1);
                end
            end

            if (publish) begin
                result_q   <= new_res;
                alarm_hi_q <= new_hi;
                alarm_lo_q <= new_lo;
            end

            if (start_ok)
                timeout_err_q <= 1'b0;
            else if (wd_exp)
                timeout_err_q <= 1'b1;
        end
    end

    assign bus.ana_en       = ana_en_c;
    assign bus.busy         = busy_c;
    assign bus.result_valid = rv_c;
    assign bus.result       = result_q;
    assign bus.alarm_hi     = alarm_hi_q;
    assign bus.alarm_lo     = alarm_lo_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: tb/tb_temp_meas_sched.sv
// Directed bench for temp_meas_sched: phase-level reference model checked every cycle,
// plus hand-computed expectations for results, alarms, spacing, timeout, stop and reset.
module tb_temp_meas_sched;
    localparam int DW          = 8;
    localparam int AVG_LOG2    = 2;
    localparam int NAVG        = 4;
    localparam int SETTLE_CYC  = 4;
    localparam int TIMEOUT_CYC = 64;
`ifdef TEMP_SCHED_HYST_EN
    localparam int HYST        = 2;
    localparam int HI_AT_99    = 1;
`else
    localparam int HI_AT_99    = 0;
`endif
    localparam int P_IDLE = 0, P_SETTLE = 1, P_MEAS = 2, P_DONE = 3, P_WAIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    temp_meas_sched_if #(.DW(DW)) bus();

    temp_meas_sched #(
        .DW(DW), .AVG_LOG2(AVG_LOG2), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
`ifdef TEMP_SCHED_HYST_EN
        , .HYST(HYST)
`endif
    ) dut (
        .lf_clk(clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;
    int rv_times[$];

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus elapsed-cycle counts, running sum and integer average.
    int m_phase = P_IDLE, m_age = 0, m_quiet = 0, m_wait_len = 0, m_sum = 0, m_cnt = 0;
    int m_result = 0;
    bit m_seen = 0, m_hi = 0, m_lo = 0, m_terr = 0;

    function automatic bit exp_hi(int r, int thr, bit prev);
`ifdef TEMP_SCHED_HYST_EN
        int clr = (thr - HYST < 0) ? 0 : thr - HYST;
        if (r > thr) return 1'b1;
        if (r < clr) return 1'b0;
        return prev;
`else
        return (r > thr) || (prev && 1'b0);
`endif
    endfunction

    function automatic bit exp_lo(int r, int thr, bit prev);
`ifdef TEMP_SCHED_HYST_EN
        int clr = (thr + HYST > 255) ? 255 : thr + HYST;
        if (r < thr) return 1'b1;
        if (r > clr) return 1'b0;
        return prev;
`else
        return (r < thr) || (prev && 1'b0);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= P_IDLE; m_age <= 0; m_quiet <= 0; m_wait_len <= 0;
            m_sum <= 0; m_cnt <= 0; m_result <= 0;
            m_seen <= 0; m_hi <= 0; m_lo <= 0; m_terr <= 0;
        end else if (bus.stop) begin
            m_phase <= P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (bus.start) begin
                    m_terr <= 0; m_phase <= P_SETTLE; m_age <= 0;
                end
                P_SETTLE: if (m_age + 1 == SETTLE_CYC) begin
                    m_phase <= P_MEAS; m_seen <= 0; m_sum <= 0; m_cnt <= 0; m_quiet <= 0;
                end else m_age <= m_age + 1;
                P_MEAS: if (bus.delta_valid) begin
                    m_quiet <= 0;
                    if (!m_seen) m_seen <= 1;
                    else if (m_cnt + 1 == NAVG) begin
                        m_result <= (m_sum + int'(bus.delta)) / NAVG;
                        m_hi <= exp_hi((m_sum + int'(bus.delta)) / NAVG, int'(bus.thr_hi), m_hi);
                        m_lo <= exp_lo((m_sum + int'(bus.delta)) / NAVG, int'(bus.thr_lo), m_lo);
                        m_phase <= P_DONE;
                    end else begin
                        m_sum <= m_sum + int'(bus.delta); m_cnt <= m_cnt + 1;
                    end
                end else if (m_quiet + 1 == TIMEOUT_CYC) begin
                    m_terr <= 1; m_phase <= P_IDLE;
                end else m_quiet <= m_quiet + 1;
                P_DONE: if (!bus.continuous) m_phase <= P_IDLE;
                else if (bus.interval == 8'd0) begin
                    m_phase <= P_SETTLE; m_age <= 0;
                end else begin
                    m_phase <= P_WAIT; m_age <= 0; m_wait_len <= int'(bus.interval);
                end
                P_WAIT: if (m_age + 1 == m_wait_len) begin
                    m_phase <= P_SETTLE; m_age <= 0;
                end else m_age <= m_age + 1;
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        check("ana_en",       int'(bus.ana_en),       int'(m_phase == P_SETTLE || m_phase == P_MEAS));
        check("busy",         int'(bus.busy),         int'(m_phase != P_IDLE));
        check("result_valid", int'(bus.result_valid), int'(m_phase == P_DONE));
        check("result",       int'(bus.result),       m_result);
        check("alarm_hi",     int'(bus.alarm_hi),     int'(m_hi));
        check("alarm_lo",     int'(bus.alarm_lo),     int'(m_lo));
        check("timeout_err",  int'(bus.timeout_err),  int'(m_terr));
        if (bus.result_valid) rv_times.push_back(cyc_n);
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc(1);
        bus.start = 1'b0;
    endtask

    task automatic send(int val, int gap, bit spam);
        repeat (gap) begin
            bus.start = spam;
            cyc(1);
        end
        bus.start       = 1'b0;
        bus.delta       = DW'(val);
        bus.delta_valid = 1'b1;
        cyc(1);
        bus.delta_valid = 1'b0;
    endtask

    task automatic run_single(int d0, int d1, int d2, int d3, int d4, bit spam,
                              int exp_res, int ehi, int elo);
        bus.continuous = 1'b0;
        pulse_start();
        send(d0, 5, spam);
        send(d1, 3, spam);
        send(d2, 3, spam);
        send(d3, 3, spam);
        send(d4, 3, spam);
        @(negedge clk);
        check("single_rv",       int'(bus.result_valid), 1);
        check("single_result",   int'(bus.result),       exp_res);
        check("single_alarm_hi", int'(bus.alarm_hi),     ehi);
        check("single_alarm_lo", int'(bus.alarm_lo),     elo);
        check("single_ana_done", int'(bus.ana_en),       0);
        cyc(1);
        @(negedge clk);
        check("single_busy_after", int'(bus.busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, n_tests=%0d", n_tests);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.start = 0; bus.stop = 0; bus.continuous = 0; bus.interval = 8'd10;
        bus.thr_hi = 8'd100; bus.thr_lo = 8'd50; bus.delta = '0; bus.delta_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_ana_en", int'(bus.ana_en),      0);
        check("reset_busy",   int'(bus.busy),        0);
        check("reset_result", int'(bus.result),      0);
        check("reset_terr",   int'(bus.timeout_err), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        run_single(99, 100, 102, 104, 106, 1'b0, 103, 1, 0);
        run_single(0, 98, 99, 100, 99, 1'b1, 99, HI_AT_99, 0);
        run_single(0, 96, 97, 98, 97, 1'b0, 97, 0, 0);

        // Continuous mode with a free-running window strobe every 4 cycles.
        rv_times.delete();
        bus.continuous = 1'b1;
        bus.interval   = 8'd10;
        pulse_start();
        for (int i = 0; i < 170; i++) begin
            if (i == 130) bus.continuous = 1'b0;
            bus.delta       = 8'd80;
            bus.delta_valid = (i % 4 == 3);
            cyc(1);
        end
        bus.delta_valid = 1'b0;
        @(negedge clk);
        check("cont_count", rv_times.size(), 5);
        for (int k = 1; k < rv_times.size(); k++)
            check("cont_spacing", rv_times[k] - rv_times[k-1], 32);
        check("cont_idle_after", int'(bus.busy), 0);

        // Watchdog: no windows after entering MEAS.
        pulse_start();
        cyc(67);
        @(negedge clk);
        check("wd_before_ana", int'(bus.ana_en),      1);
        check("wd_before_err", int'(bus.timeout_err), 0);
        cyc(1);
        @(negedge clk);
        check("wd_err",    int'(bus.timeout_err), 1);
        check("wd_ana",    int'(bus.ana_en),      0);
        check("wd_busy",   int'(bus.busy),        0);
        check("wd_result", int'(bus.result),      80);
        pulse_start();
        @(negedge clk);
        check("wd_clear", int'(bus.timeout_err), 0);
        check("wd_busy2", int'(bus.busy),        1);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        @(negedge clk);
        check("stop_settle_busy", int'(bus.busy), 0);

        // Abort in MEAS after two accepted samples.
        pulse_start();
        send(50, 5, 1'b0);
        send(60, 3, 1'b0);
        send(60, 3, 1'b0);
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
        @(negedge clk);
        check("stop_meas_busy",   int'(bus.busy),         0);
        check("stop_meas_rv",     int'(bus.result_valid), 0);
        check("stop_meas_result", int'(bus.result),       80);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        @(negedge clk);
        check("start_stop_busy", int'(bus.busy), 0);

        run_single(39, 39, 40, 41, 42, 1'b0, 40, 0, 1);

        // Asynchronous reset in the middle of MEAS.
        pulse_start();
        send(10, 5, 1'b0);
        send(20, 3, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ana_en",   int'(bus.ana_en),   0);
        check("arst_busy",     int'(bus.busy),     0);
        check("arst_result",   int'(bus.result),   0);
        check("arst_alarm_hi", int'(bus.alarm_hi), 0);
        check("arst_alarm_lo", int'(bus.alarm_lo), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        @(negedge clk);
        check("arst_idle_busy", int'(bus.busy),   0);
        check("arst_idle_ana",  int'(bus.ana_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
